// File: rtl/csr_queue.sv
// In-order CSR operation queue between issue and commit, with occupancy count and commit-underflow flag.
// Optional landing-pad target remapping is enabled by defining CSR_QUEUE_LP_REMAP_EN.
package csr_queue_pkg;
  typedef enum logic [3:0] {
    CSRRW, CSRRS, CSRRC, CSRRWI, LPSLL, LPSML, LPSUL, LPCLL
  } fu_op;

  localparam logic [11:0] CSR_ELP  = 12'h808;
  localparam logic [11:0] CSR_LPLR = 12'h80a;
endpackage

module csr_queue
  import csr_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 12
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  fu_op                     operator_i,
  input  logic [DATA_W-1:0]        operand_a_i,
  input  logic [DATA_W-1:0]        operand_b_i,
  input  logic                     elp_init_i,
  output logic [DATA_W-1:0]        result_o,
  input  logic                     commit_i,
  output logic                     commit_valid_o,
  output logic [ADDR_W-1:0]        commit_addr_o,
  output logic [DATA_W-1:0]        commit_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     commit_err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  logic [PTR_W-1:0]  wr_ptr, wr_ptr_n;
  logic [PTR_W-1:0]  rd_ptr, rd_ptr_n;
  logic [CNT_W-1:0]  count, count_n;
  logic [ADDR_W-1:0] head_addr, head_addr_n;
  logic [DATA_W-1:0] head_data, head_data_n;
  logic              err;
  logic              push, pop;
  logic [ADDR_W-1:0] target;
  logic              unused_inputs;

`ifdef CSR_QUEUE_LP_REMAP_EN
  function automatic logic [ADDR_W-1:0] sel_target(input fu_op op, input logic elp,
                                                   input logic [ADDR_W-1:0] csr);
    if (op == LPSLL || op == LPSML || op == LPSUL) return ADDR_W'(CSR_LPLR);
    if (op == LPCLL)                               return ADDR_W'(CSR_ELP);
    if (elp)                                       return ADDR_W'(CSR_ELP);
    return csr;
  endfunction

  assign target        = sel_target(operator_i, elp_init_i, operand_b_i[ADDR_W-1:0]);
  assign unused_inputs = ^operand_b_i[DATA_W-1:ADDR_W];
`else
  assign target        = operand_b_i[ADDR_W-1:0];
  assign unused_inputs = ^{operand_b_i[DATA_W-1:ADDR_W], operator_i, elp_init_i};
`endif

  assign ready_o  = (count < CNT_W'(DEPTH)) | commit_i;
  assign result_o = operand_a_i;
  assign push     = valid_i & ready_o & ~flush_i;
  assign pop      = commit_i & (count != '0) & ~flush_i;

  always_comb begin
    wr_ptr_n    = wr_ptr;
    rd_ptr_n    = rd_ptr;
    count_n     = count;
    head_addr_n = head_addr;
    head_data_n = head_data;
    if (flush_i) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      count_n  = '0;
    end else begin
      if (push) wr_ptr_n = wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr_n = rd_ptr + PTR_W'(1);
      if (push && !pop)      count_n = count + CNT_W'(1);
      else if (pop && !push) count_n = count - CNT_W'(1);
    end
    // Head registers track the entry at the next read pointer; an entry written
    // this cycle is forwarded so it lands at the head one cycle after acceptance.
    if (count_n != '0) begin
      if (push && wr_ptr == rd_ptr_n) begin
        head_addr_n = target;
        head_data_n = operand_a_i;
      end else begin
        head_addr_n = mem_addr[rd_ptr_n];
        head_data_n = mem_data[rd_ptr_n];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_addr[wr_ptr] <= target;
      mem_data[wr_ptr] <= operand_a_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      head_addr <= '0;
      head_data <= '0;
      err       <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      head_addr <= head_addr_n;
      head_data <= head_data_n;
      err       <= commit_i & (count == '0) & ~flush_i;
    end
  end

  assign commit_valid_o = (count != '0);
  assign commit_addr_o  = head_addr;
  assign commit_data_o  = head_data;
  assign count_o        = count;
  assign commit_err_o   = err;

endmodule

// File: tb/tb_csr_queue.sv
// Scoreboard bench for csr_queue: randomized and directed stimulus checked against a queue-based model.
module tb_csr_queue;
  import csr_queue_pkg::*;

  localparam int DEPTH = 4;
`ifdef CSR_QUEUE_LP_REMAP_EN
  localparam bit REMAP = 1'b1;
`else
  localparam bit REMAP = 1'b0;
`endif

  typedef struct packed {
    logic [11:0] addr;
    logic [63:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  fu_op        operator_i = CSRRW;
  logic [63:0] operand_a_i = '0;
  logic [63:0] operand_b_i = '0;
  logic        elp_init_i = 1'b0;
  logic [63:0] result_o;
  logic        commit_i = 1'b0;
  logic        commit_valid_o;
  logic [11:0] commit_addr_o;
  logic [63:0] commit_data_o;
  logic [2:0]  count_o;
  logic        commit_err_o;

  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  ent_t mq[$];
  ent_t held = '0;
  logic err_exp = 1'b0;

  csr_queue #(.DEPTH(DEPTH), .DATA_W(64), .ADDR_W(12)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .operator_i(operator_i), .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
    .elp_init_i(elp_init_i), .result_o(result_o), .commit_i(commit_i),
    .commit_valid_o(commit_valid_o), .commit_addr_o(commit_addr_o),
    .commit_data_o(commit_data_o), .count_o(count_o), .commit_err_o(commit_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] tgt(input fu_op op, input logic elp, input logic [11:0] csr);
    if (REMAP && (op == LPSLL || op == LPSML || op == LPSUL)) return CSR_LPLR;
    if (REMAP && (op == LPCLL || elp)) return CSR_ELP;
    return csr;
  endfunction

  // Monitor: compares outputs against the model, then advances the model by this cycle's inputs.
  always @(negedge clk) begin
    int   sz;
    ent_t e;
    if (mon_en && !rst_i) begin
      sz = mq.size();
      check("count", 64'(count_o), 64'(sz));
      check("commit_valid", 64'(commit_valid_o), 64'(sz != 0));
      check("ready", 64'(ready_o), 64'((sz < DEPTH) || commit_i));
      check("commit_err", 64'(commit_err_o), 64'(err_exp));
      check("result", result_o, operand_a_i);
      if (sz != 0) held = mq[0];
      check("head_addr", 64'(commit_addr_o), 64'(held.addr));
      check("head_data", commit_data_o, held.data);
      err_exp = commit_i && (sz == 0) && !flush_i;
      if (flush_i) begin
        mq.delete();
      end else begin
        if (commit_i && sz != 0) e = mq.pop_front();
        if (valid_i && (sz < DEPTH || commit_i)) begin
          e.addr = tgt(operator_i, elp_init_i, operand_b_i[11:0]);
          e.data = operand_a_i;
          mq.push_back(e);
        end
      end
    end
  end

  task automatic drive(input logic v, input fu_op op, input logic [63:0] a, input logic [63:0] b,
                       input logic e, input logic c, input logic f);
    @(posedge clk);
    #1;
    valid_i = v; operator_i = op; operand_a_i = a; operand_b_i = b;
    elp_init_i = e; commit_i = c; flush_i = f;
  endtask

  task automatic idle();
    drive(1'b0, CSRRW, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #12;
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_valid", 64'(commit_valid_o), 64'd0);
    check("rst_addr", 64'(commit_addr_o), 64'd0);
    check("rst_data", commit_data_o, 64'd0);
    check("rst_err", 64'(commit_err_o), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd1);
    @(posedge clk);
    #1 rst_i = 1'b0;
    mon_en = 1'b1;

    // In-order push of three ops, then three commits
    drive(1'b1, CSRRW, 64'hA, 64'h300, 1'b0, 1'b0, 1'b0);
    drive(1'b1, CSRRS, 64'hB, 64'h341, 1'b0, 1'b0, 1'b0);
    drive(1'b1, CSRRC, 64'hC, 64'h305, 1'b0, 1'b0, 1'b0);
    idle();
    check("count_three", 64'(count_o), 64'd3);
    repeat (3) drive(1'b0, CSRRW, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
    idle();
    check("empty_after_three", 64'(commit_valid_o), 64'd0);

    // Fill, push alongside commit when full, then wrap with push+pop
    for (int i = 0; i < DEPTH; i++) drive(1'b1, CSRRW, 64'(16 + i), 64'(12'h100 + i), 1'b0, 1'b0, 1'b0);
    drive(1'b1, CSRRW, 64'h55, 64'h1ff, 1'b0, 1'b0, 1'b0);
    drive(1'b1, CSRRW, 64'h66, 64'h1fe, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2 * DEPTH; i++) drive(1'b1, CSRRWI, 64'(32 + i), 64'(12'h200 + i), 1'b0, 1'b1, 1'b0);
    repeat (DEPTH + 1) drive(1'b0, CSRRW, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);

    // Target remapping
    drive(1'b1, LPSLL, 64'h1, 64'h123, 1'b0, 1'b0, 1'b0);
    drive(1'b1, LPCLL, 64'h2, 64'h123, 1'b0, 1'b0, 1'b0);
    drive(1'b1, CSRRW, 64'h3, 64'h123, 1'b1, 1'b0, 1'b0);
    drive(1'b1, LPSUL, 64'h4, 64'h124, 1'b0, 1'b0, 1'b0);
    idle();
    check("remap_head", 64'(commit_addr_o), REMAP ? 64'(CSR_LPLR) : 64'h123);
    repeat (4) drive(1'b0, CSRRW, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);

    // Flush with push and commit in the same cycle
    drive(1'b1, CSRRW, 64'h71, 64'h310, 1'b0, 1'b0, 1'b0);
    drive(1'b1, CSRRW, 64'h72, 64'h311, 1'b0, 1'b0, 1'b0);
    drive(1'b1, CSRRW, 64'h73, 64'h312, 1'b0, 1'b1, 1'b1);
    idle();
    check("flush_count", 64'(count_o), 64'd0);
    drive(1'b1, CSRRW, 64'h74, 64'h313, 1'b0, 1'b0, 1'b0);
    drive(1'b0, CSRRW, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);

    // Commit on empty queue
    drive(1'b0, CSRRW, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
    idle();
    idle();

    // Asynchronous reset with three entries held
    for (int i = 0; i < 3; i++) drive(1'b1, CSRRS, 64'(80 + i), 64'(12'h340 + i), 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    valid_i = 1'b0; commit_i = 1'b0;
    #1;
    mon_en = 1'b0;
    rst_i = 1'b1;
    #1;
    check("arst_count", 64'(count_o), 64'd0);
    check("arst_valid", 64'(commit_valid_o), 64'd0);
    check("arst_addr", 64'(commit_addr_o), 64'd0);
    check("arst_data", commit_data_o, 64'd0);
    check("arst_ready", 64'(ready_o), 64'd1);
    mq.delete();
    held = '0;
    err_exp = 1'b0;
    @(posedge clk);
    #1 rst_i = 1'b0;
    mon_en = 1'b1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 60, fu_op'($urandom_range(0, 7)), {$urandom, $urandom},
            64'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 99) < 45,
            $urandom_range(0, 99) < 3);
    end
    repeat (DEPTH + 2) drive(1'b0, CSRRW, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
    idle();
    idle();
    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/csr_queue.md
# csr_queue

Multi-entry, parametrised CSR operation queue that sits between issue and commit as a functional unit to the scoreboard. Up to DEPTH outstanding CSR operations are accepted in order; the CSR address and write data of each are held until the commit stage retires them in order. The block generalises the single-entry CSR address buffer: it adds configurable depth, a stored write-data path, an occupancy count and commit-underflow detection. Landing-pad (CFI) operators can optionally have their target CSR rewritten on entry.

## Interface
Parameters:
- DEPTH, 4, number of queue entries; power of two, ≥ 2
- DATA_W, riscv::XLEN, width of operands and stored write data
- ADDR_W, 12, CSR address width

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- flush_i  in  1  discard all entries
- valid_i  in  1  new CSR operation offered
- ready_o  out  1  queue can accept an operation this cycle
- operator_i  in  fu_op  operation code of offered op
- operand_a_i  in  DATA_W  CSR write data
- operand_b_i  in  DATA_W  CSR address in [ADDR_W-1:0]
- elp_init_i  in  1  force ELP CSR target for non-LP ops
- result_o  out  DATA_W  scoreboard result, equal to operand_a_i (combinational)
- commit_i  in  1  retire head entry
- commit_valid_o  out  1  head entry present
- commit_addr_o  out  ADDR_W  head CSR address
- commit_data_o  out  DATA_W  head write data
- count_o  out  $clog2(DEPTH)+1  occupancy
- commit_err_o  out  1  registered pulse: commit_i with empty queue

## Operation
- Storage: DEPTH entries of {addr, data}; wr_ptr and rd_ptr each $clog2(DEPTH) bits, wrapping modulo DEPTH; count register 0..DEPTH.
- Push = valid_i & ready_o & ~flush_i. Writes {target_addr, operand_a_i} at wr_ptr; wr_ptr+1.
- ready_o = (count < DEPTH) | commit_i. When full, a push is accepted only alongside a commit.
- Pop = commit_i & (count != 0) & ~flush_i. rd_ptr+1.
- Count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Head outputs: commit_valid_o = (count != 0); commit_addr_o/commit_data_o = entry at rd_ptr. When empty, they hold the last-read entry value; they are 0 after reset.
- commit_i with count == 0 and no flush: no state change; commit_err_o = 1 on the next cycle for one cycle.
- Flush: wr_ptr = rd_ptr = count = 0. Flush takes priority over a push or pop in the same cycle. Entry storage is not cleared.
- Target address selection (see Configuration):
  - LPSLL, LPSML, LPSUL → CSR_LPLR
  - LPCLL → CSR_ELP
  - otherwise, elp_init_i = 1 → CSR_ELP
  - otherwise operand_b_i[ADDR_W-1:0]

## Timing
- Reset (rst_i = 1, asynchronous): count_o = 0, commit_valid_o = 0, commit_addr_o = 0, commit_data_o = 0, commit_err_o = 0, pointers = 0, ready_o = 1. Reset asserted mid-operation drops all entries immediately, with no dependence on the clock.
- Push latency: an operation accepted in cycle N is visible at the head in cycle N+1 if the queue was empty. The block has no bypass to the head outputs in the accept cycle.
- Pop: the new head is presented in the cycle after the commit edge.
- Pointer wrap: from DEPTH-1 the next value is 0, with no bubble.
- ready_o and result_o are combinational from count, commit_i and operand_a_i. No other output depends combinationally on an input.

## Configuration
- Macro CSR_QUEUE_LP_REMAP_EN.
- Defined: the target-address selection above applies, including elp_init_i.
- Undefined: target = operand_b_i[ADDR_W-1:0] for every operator. elp_init_i and operator_i are ignored; the ports remain present.

## Test plan
- Reset, then push 3 ops with addresses 0x300, 0x341, 0x305 and data 0xA, 0xB, 0xC → count_o = 3; three commits return those addresses and data in order; commit_valid_o = 0 after the third.
- DEPTH = 4: push 4 ops → ready_o = 0. Push a 5th with commit_i = 1 in the same cycle → accepted, count_o stays 4, head advances. After ≥ DEPTH cycles of push+pop, pointers have wrapped and FIFO order is preserved.
- Macro defined: operator LPSLL with operand_b_i = 0x123 → commit_addr_o = CSR_LPLR. LPCLL → CSR_ELP. A plain op with elp_init_i = 1 → CSR_ELP. Macro undefined: the same stimulus yields 0x123.
- With 2 entries held, assert flush_i together with valid_i and commit_i → next cycle count_o = 0, commit_valid_o = 0, ready_o = 1, and no entry was written.
- commit_i with an empty queue → commit_err_o = 1 for exactly one cycle; count_o stays 0.
- Assert rst_i asynchronously mid-cycle with 3 entries held → count_o = 0, commit_valid_o = 0 and commit_addr_o = 0 before the next clock edge.
